glyph_sprite: RTL and testbench

Parametrised VGA digit-sprite renderer: draws one 32×16 glyph, selectable from digits 0–9, at a registered screen position. With motion enabled, the glyph moves by a configurable velocity once per frame and bounces off the screen edges. It sits beside the other sprite/logo blocks, between the VGA sync generator (pix_x, pix_y, video_on, refr_tick) and the RGB priority mux.

---
 rtl/sprite_pkg.sv | 17 +
 rtl/glyph_rom.sv | 51 +++++
 rtl/glyph_sprite.sv | 145 ++++++++++++++
 tb/tb_glyph_sprite.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared glyph geometry and bounce-direction state encoding for the digit sprite.
package sprite_pkg;

  localparam int GLYPH_W = 32;
  localparam int GLYPH_H = 16;

  localparam logic [31:0] BLANK_ROW = 32'h0;

  // Encoded as {dir_y, dir_x}: dir_x 1 = moving left, dir_y 1 = moving up
  typedef enum logic [1:0] {
    DR = 2'b00,
    DL = 2'b01,
    UR = 2'b10,
    UL = 2'b11
  } dir_t;

endpackage

// File: rtl/glyph_rom.sv
// Combinational seven-segment style digit font, 32 columns x 16 rows, MSB = leftmost pixel.
module glyph_rom
  import sprite_pkg::*;
(
  input  logic [3:0]  digit,
  input  logic [3:0]  row,
  output logic [31:0] data
);

  localparam logic [31:0] HBAR  = 32'h0FFF_FFF0;
  localparam logic [31:0] LBAR  = 32'h0F00_0000;
  localparam logic [31:0] RBAR  = 32'h0000_00F0;

  // segs = {g, f, e, d, c, b, a}
  logic [6:0] segs;
  logic       upper;
  logic       lower;

  always_comb begin
    segs = 7'h00;
    case (digit)
      4'd0: segs = 7'h3F;
      4'd1: segs = 7'h06;
      4'd2: segs = 7'h5B;
      4'd3: segs = 7'h4F;
      4'd4: segs = 7'h66;
      4'd5: segs = 7'h6D;
      4'd6: segs = 7'h7D;
      4'd7: segs = 7'h07;
      4'd8: segs = 7'h7F;
      4'd9: segs = 7'h6F;
      default: segs = 7'h00;
    endcase
  end

  // Upper and lower vertical strokes overlap on rows 7-8 so they join the middle bar
  assign upper = (row <= 4'd8);
  assign lower = (row >= 4'd7);

  always_comb begin
    data = BLANK_ROW;
    if (segs[0] && row <= 4'd1)               data = data | HBAR;
    if (segs[6] && (row == 4'd7 || row == 4'd8)) data = data | HBAR;
    if (segs[3] && row >= 4'd14)              data = data | HBAR;
    if (segs[5] && upper)                     data = data | LBAR;
    if (segs[1] && upper)                     data = data | RBAR;
    if (segs[4] && lower)                     data = data | LBAR;
    if (segs[2] && lower)                     data = data | RBAR;
  end

endmodule

// File: rtl/glyph_sprite.sv
// VGA digit-sprite renderer with optional per-frame bouncing motion.
// Motion, direction FSM, edge_hit and bounce_cnt are built only when SPRITE_BOUNCE_EN is defined.
module glyph_sprite
  import sprite_pkg::*;
#(
  parameter int          X_INIT = 300,
  parameter int          Y_INIT = 10,
  parameter int          SCR_W  = 640,
  parameter int          SCR_H  = 480,
  parameter int          VEL_X  = 1,
  parameter int          VEL_Y  = 1,
  parameter logic [2:0]  RGB    = 3'b101
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       video_on,
  input  logic       refr_tick,
  input  logic [9:0] pix_x,
  input  logic [9:0] pix_y,
  input  logic [3:0] digit,
  input  logic       move_en,
  output logic       sprite_on,
  output logic [2:0] sprite_rgb,
  output logic       edge_hit,
  output logic [7:0] bounce_cnt
);

  logic [9:0]  x_reg;
  logic [9:0]  y_reg;
  logic [3:0]  digit_q;

  logic [10:0] dx;
  logic [10:0] dy;
  logic        hit;
  logic [31:0] rom_data;
  logic        pix_bit;

  // Hit test in 11 bits so a glyph near the right/bottom edge cannot wrap
  assign dx  = {1'b0, pix_x} - {1'b0, x_reg};
  assign dy  = {1'b0, pix_y} - {1'b0, y_reg};
  assign hit = (pix_x >= x_reg) && (dx < 11'(GLYPH_W)) &&
               (pix_y >= y_reg) && (dy < 11'(GLYPH_H));

  glyph_rom u_rom (
    .digit (digit_q),
    .row   (dy[3:0]),
    .data  (rom_data)
  );

  assign pix_bit = rom_data[5'd31 - dx[4:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      digit_q    <= 4'd0;
      sprite_on  <= 1'b0;
      sprite_rgb <= 3'b000;
    end else begin
      sprite_on  <= video_on && hit && pix_bit;
      sprite_rgb <= (video_on && hit && pix_bit) ? RGB : 3'b000;
      if (refr_tick) digit_q <= digit;
    end
  end

`ifdef SPRITE_BOUNCE_EN
  localparam logic [10:0] VX   = 11'(VEL_X);
  localparam logic [10:0] VY   = 11'(VEL_Y);
  localparam logic [10:0] XMAX = 11'(SCR_W - GLYPH_W);
  localparam logic [10:0] YMAX = 11'(SCR_H - GLYPH_H);

  dir_t        state;
  dir_t        state_next;
  logic [9:0]  x_next;
  logic [9:0]  y_next;
  logic        flip_x;
  logic        flip_y;
  logic [10:0] cand_x;
  logic [10:0] cand_y;

  always_comb begin
    x_next = x_reg;
    y_next = y_reg;
    flip_x = 1'b0;
    flip_y = 1'b0;
    cand_x = {1'b0, x_reg} + VX;
    cand_y = {1'b0, y_reg} + VY;
    if (!state[0]) begin
      if (cand_x > XMAX) begin
        x_next = XMAX[9:0];
        flip_x = 1'b1;
      end else begin
        x_next = cand_x[9:0];
      end
    end else if ({1'b0, x_reg} < VX) begin
      x_next = 10'd0;
      flip_x = 1'b1;
    end else begin
      x_next = x_reg - VX[9:0];
    end
    if (!state[1]) begin
      if (cand_y > YMAX) begin
        y_next = YMAX[9:0];
        flip_y = 1'b1;
      end else begin
        y_next = cand_y[9:0];
      end
    end else if ({1'b0, y_reg} < VY) begin
      y_next = 10'd0;
      flip_y = 1'b1;
    end else begin
      y_next = y_reg - VY[9:0];
    end
    state_next = dir_t'({state[1] ^ flip_y, state[0] ^ flip_x});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      x_reg      <= 10'(X_INIT);
      y_reg      <= 10'(Y_INIT);
      state      <= DR;
      edge_hit   <= 1'b0;
      bounce_cnt <= 8'd0;
    end else begin
      edge_hit <= 1'b0;
      if (refr_tick && move_en) begin
        x_reg    <= x_next;
        y_reg    <= y_next;
        state    <= state_next;
        // A corner flips both axes but is still one bounce event
        edge_hit <= flip_x || flip_y;
        if ((flip_x || flip_y) && bounce_cnt != 8'hFF)
          bounce_cnt <= bounce_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_move_en;

  assign unused_move_en = move_en;
  assign x_reg          = 10'(X_INIT);
  assign y_reg          = 10'(Y_INIT);
  assign edge_hit       = 1'b0;
  assign bounce_cnt     = 8'd0;
`endif

endmodule

// File: tb/tb_glyph_sprite.sv
// Bench for glyph_sprite: three instances with different geometry checked against a frame-level model.
module tb_glyph_sprite;

`ifdef SPRITE_BOUNCE_EN
  localparam bit BOUNCE = 1'b1;
`else
  localparam bit BOUNCE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       video_on = 1'b0;
  logic       refr_tick = 1'b0;
  logic [9:0] pix_x = 10'd0;
  logic [9:0] pix_y = 10'd0;
  logic [3:0] digit = 4'd0;
  logic       move_en = 1'b0;

  logic       on_w  [3];
  logic [2:0] rgb_w [3];
  logic       hit_w [3];
  logic [7:0] cnt_w [3];
  logic [9:0] xr    [3];
  logic [9:0] yr    [3];

  always #5 clk = ~clk;

  glyph_sprite #(.X_INIT(300), .Y_INIT(10)) dut0 (
    .clk(clk), .reset(reset), .video_on(video_on), .refr_tick(refr_tick),
    .pix_x(pix_x), .pix_y(pix_y), .digit(digit), .move_en(move_en),
    .sprite_on(on_w[0]), .sprite_rgb(rgb_w[0]), .edge_hit(hit_w[0]), .bounce_cnt(cnt_w[0]));

  glyph_sprite #(.X_INIT(606), .Y_INIT(10), .VEL_X(2)) dut1 (
    .clk(clk), .reset(reset), .video_on(video_on), .refr_tick(refr_tick),
    .pix_x(pix_x), .pix_y(pix_y), .digit(digit), .move_en(move_en),
    .sprite_on(on_w[1]), .sprite_rgb(rgb_w[1]), .edge_hit(hit_w[1]), .bounce_cnt(cnt_w[1]));

  glyph_sprite #(.X_INIT(0), .Y_INIT(0), .SCR_W(64), .SCR_H(48)) dut2 (
    .clk(clk), .reset(reset), .video_on(video_on), .refr_tick(refr_tick),
    .pix_x(pix_x), .pix_y(pix_y), .digit(digit), .move_en(move_en),
    .sprite_on(on_w[2]), .sprite_rgb(rgb_w[2]), .edge_hit(hit_w[2]), .bounce_cnt(cnt_w[2]));

  assign xr[0] = dut0.x_reg;
  assign yr[0] = dut0.y_reg;
  assign xr[1] = dut1.x_reg;
  assign yr[1] = dut1.y_reg;
  assign xr[2] = dut2.x_reg;
  assign yr[2] = dut2.y_reg;

  int XI [3] = '{300, 606, 0};
  int YI [3] = '{10, 10, 0};
  int VX [3] = '{1, 2, 1};
  int VY [3] = '{1, 1, 1};
  int XM [3] = '{608, 608, 32};
  int YM [3] = '{464, 464, 32};

  // Font as segment sets {g,f,e,d,c,b,a} over fixed stroke rectangles
  logic [6:0] SEGS [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int mx [3], my [3], mdx [3], mdy [3], mcnt [3];
  int mdig;
  bit exp_on [3];
  bit exp_hit [3];
  bit checking = 1'b0;

  int vectors = 0;
  int fails = 0;

  function automatic bit lit(int d, int r, int c);
    logic [6:0] s;
    bit hz, lv, rv, up, lo;
    if (d > 9) return 1'b0;
    s  = SEGS[d];
    hz = (c >= 4 && c <= 27);
    lv = (c >= 4 && c <= 7);
    rv = (c >= 24 && c <= 27);
    up = (r <= 8);
    lo = (r >= 7);
    return (s[0] && r <= 1 && hz) || (s[6] && (r == 7 || r == 8) && hz) ||
           (s[3] && r >= 14 && hz) || (s[5] && up && lv) || (s[1] && up && rv) ||
           (s[4] && lo && lv) || (s[2] && lo && rv);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: screen position, bounce direction as +/-1, event counter
  initial begin
    forever begin
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
        exp_hit[i] = 1'b0;
        if (reset) begin
          mx[i] = XI[i]; my[i] = YI[i]; mdx[i] = 1; mdy[i] = 1; mcnt[i] = 0;
          exp_on[i] = 1'b0;
        end else begin
          exp_on[i] = video_on && (int'(pix_x) >= mx[i]) && (int'(pix_x) <= mx[i] + 31) &&
                      (int'(pix_y) >= my[i]) && (int'(pix_y) <= my[i] + 15) &&
                      lit(mdig, int'(pix_y) - my[i], int'(pix_x) - mx[i]);
          if (BOUNCE && refr_tick && move_en) begin
            int nx, ny;
            bit f;
            f  = 1'b0;
            nx = mx[i] + mdx[i] * VX[i];
            ny = my[i] + mdy[i] * VY[i];
            if (nx > XM[i])  begin mx[i] = XM[i]; mdx[i] = -mdx[i]; f = 1'b1; end
            else if (nx < 0) begin mx[i] = 0;     mdx[i] = -mdx[i]; f = 1'b1; end
            else mx[i] = nx;
            if (ny > YM[i])  begin my[i] = YM[i]; mdy[i] = -mdy[i]; f = 1'b1; end
            else if (ny < 0) begin my[i] = 0;     mdy[i] = -mdy[i]; f = 1'b1; end
            else my[i] = ny;
            if (f) begin
              exp_hit[i] = 1'b1;
              if (mcnt[i] < 255) mcnt[i]++;
            end
          end
        end
      end
      if (reset) mdig = 0;
      else if (refr_tick) mdig = int'(digit);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (checking) begin
        for (int i = 0; i < 3; i++) begin
          chk($sformatf("on%0d", i), int'(on_w[i]), int'(exp_on[i]));
          chk($sformatf("rgb%0d", i), int'(rgb_w[i]), exp_on[i] ? 5 : 0);
          chk($sformatf("hit%0d", i), int'(hit_w[i]), int'(exp_hit[i]));
          chk($sformatf("cnt%0d", i), int'(cnt_w[i]), mcnt[i]);
          chk($sformatf("x%0d", i), int'(xr[i]), mx[i]);
          chk($sformatf("y%0d", i), int'(yr[i]), my[i]);
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    refr_tick = 1'b1;
    video_on  = 1'b0;
    @(negedge clk);
    refr_tick = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input bit von);
    @(negedge clk);
    pix_x    = 10'(x);
    pix_y    = 10'(y);
    video_on = von;
    @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_x", int'(xr[0]), 300);
    chk("rst_y", int'(yr[0]), 10);
    chk("rst_on", int'(on_w[0]), 0);
    chk("rst_cnt", int'(cnt_w[0]), 0);
    chk("rst_hit", int'(hit_w[0]), 0);
    checking = 1'b1;
    reset = 1'b0;

    digit = 4'd1;
    move_en = 1'b0;
    tick();
    // Digit 1, row 0: only the right stroke, columns 24..27
    for (int x = 300; x <= 331; x++) begin
      pix(x, 10, 1'b1);
      chk("static_on", int'(on_w[0]), (x >= 324 && x <= 327) ? 1 : 0);
    end

    digit = 4'd7;
    pix(310, 10, 1'b1);
    chk("tear_old", int'(on_w[0]), 0);
    tick();
    pix(310, 10, 1'b1);
    chk("tear_new", int'(on_w[0]), 1);
    chk("tear_rgb", int'(rgb_w[0]), 5);

    pix(310, 10, 1'b0);
    chk("gate_on", int'(on_w[0]), 0);
    chk("gate_rgb", int'(rgb_w[0]), 0);

    digit = 4'd12;
    tick();
    pix(310, 10, 1'b1);
    chk("blank_on", int'(on_w[0]), 0);
    digit = 4'd7;
    tick();

    move_en = 1'b1;
    tick();
    chk("rb1_x", int'(xr[1]), BOUNCE ? 608 : 606);
    chk("rb1_hit", int'(hit_w[1]), 0);
    tick();
    chk("rb2_x", int'(xr[1]), BOUNCE ? 608 : 606);
    chk("rb2_hit", int'(hit_w[1]), BOUNCE ? 1 : 0);
    chk("rb2_cnt", int'(cnt_w[1]), BOUNCE ? 1 : 0);
    @(negedge clk);
    chk("rb3_hit", int'(hit_w[1]), 0);

    // dut2 reaches (32,32) after 32 ticks, corners on tick 33, returns to origin on tick 65
    repeat (31) tick();
    chk("cor1_cnt", int'(cnt_w[2]), BOUNCE ? 1 : 0);
    repeat (32) tick();
    chk("cor2_x", int'(xr[2]), 0);
    chk("cor2_y", int'(yr[2]), 0);
    tick();
    chk("cor3_hit", int'(hit_w[2]), BOUNCE ? 1 : 0);
    chk("cor3_cnt", int'(cnt_w[2]), BOUNCE ? 2 : 0);
    @(negedge clk);
    chk("cor4_hit", int'(hit_w[2]), 0);

    repeat (10) tick();
    chk("nb_x", int'(xr[0]), BOUNCE ? mx[0] : 300);

    @(negedge clk);
    refr_tick = 1'b1;
    repeat (9000) @(negedge clk);
    refr_tick = 1'b0;
    @(negedge clk);
    chk("sat_cnt", int'(cnt_w[2]), BOUNCE ? 255 : 0);

    @(negedge clk);
    video_on = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("mid_rst_x", int'(xr[0]), 300);
    chk("mid_rst_cnt", int'(cnt_w[2]), 0);
    pix(310, 10, 1'b1);
    chk("post_rst_on", int'(on_w[0]), 1);

    @(negedge clk);
    checking = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
